// File: rtl/dspl_bin2digits.sv
// Binary-to-BCD formatter for the 8-digit seven-segment driver: a sequential
// double-dabble converter followed by blanking, decimal point and overflow formatting.
module dspl_bin2digits #(
  parameter int VALUE_W   = 27,
  parameter int MAX_VALUE = 99999999
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [VALUE_W-1:0] value_in,
  input  logic               blank_lz,
  input  logic               dp_en,
  input  logic [2:0]         dp_pos,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [5:0]         d1,
  output logic [5:0]         d2,
  output logic [5:0]         d3,
  output logic [5:0]         d4,
  output logic [5:0]         d5,
  output logic [5:0]         d6,
  output logic [5:0]         d7,
  output logic [5:0]         d8
);

  localparam int          CNT_W    = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam logic [31:0] MAX_U    = 32'(MAX_VALUE);
  localparam logic [5:0]  WORD_OFF = 6'b000001;
  localparam logic [5:0]  WORD_E   = 6'b111101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    FORMAT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [31:0]        bcd_q, bcd_d;
  logic               blank_q, blank_d;
  logic               dp_en_q, dp_en_d;
  logic [2:0]         dp_pos_q, dp_pos_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [7:0][5:0]    digits_q, digits_d;

  logic [31:0]        value_ext;
  logic [31:0]        bcd_adj;
  logic [7:0][5:0]    fmt_words;

  assign value_ext = 32'(value_in);

  // Every BCD nibble that would exceed 9 after doubling is pre-corrected by +3.
  function automatic logic [31:0] add3_all(input logic [31:0] b);
    logic [31:0] r;
    r = b;
    for (int i = 0; i < 8; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign bcd_adj = add3_all(bcd_q);

  // Digit words from the finished BCD accumulator; a digit stays lit when any
  // nibble at or above it is nonzero, so scanning from d8 down gives blanking.
  always_comb begin
    logic seen;
    logic en;
    logic dp_here;
    seen      = 1'b0;
    en        = 1'b0;
    dp_here   = 1'b0;
    fmt_words = {8{WORD_OFF}};
    for (int k = 7; k >= 0; k--) begin
      seen    = seen | (bcd_q[4*k +: 4] != 4'd0);
      dp_here = dp_en_q && (3'(k) == dp_pos_q);
      en      = !blank_q || seen || (dp_en_q && (3'(k) <= dp_pos_q)) || (k == 0);
      fmt_words[k] = en ? {1'b1, bcd_q[4*k +: 4], !dp_here} : WORD_OFF;
    end
    if (ovf_pend_q) fmt_words = {{7{WORD_OFF}}, WORD_E};
  end

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned; otherwise synthesis infers latches.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    blank_d    = blank_q;
    dp_en_d    = dp_en_q;
    dp_pos_d   = dp_pos_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    digits_d   = digits_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d      = value_in;
          bcd_d      = '0;
          blank_d    = blank_lz;
          dp_en_d    = dp_en;
          dp_pos_d   = dp_pos;
          cnt_d      = CNT_W'(VALUE_W - 1);
          ovf_pend_d = (value_ext > MAX_U);
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d = {bcd_adj[30:0], bin_q[VALUE_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = FORMAT;
      end
      FORMAT: begin
        digits_d = fmt_words;
        ovf_d    = ovf_pend_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      blank_q    <= 1'b0;
      dp_en_q    <= 1'b0;
      dp_pos_q   <= 3'd0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      digits_q   <= {8{WORD_OFF}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      blank_q    <= blank_d;
      dp_en_q    <= dp_en_d;
      dp_pos_q   <= dp_pos_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      digits_q   <= digits_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign d1       = digits_q[0];
  assign d2       = digits_q[1];
  assign d3       = digits_q[2];
  assign d4       = digits_q[3];
  assign d5       = digits_q[4];
  assign d6       = digits_q[5];
  assign d7       = digits_q[6];
  assign d8       = digits_q[7];

endmodule

// File: tb/tb_dspl_bin2digits.sv
// Self-checking bench for dspl_bin2digits: fixed vector table, random values
// against a decimal-arithmetic model, and start/reset timing sequences.
module tb_dspl_bin2digits;

  localparam int          VW   = 27;
  localparam int unsigned MAXV = 99999999;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [VW-1:0] value_in;
  logic          blank_lz;
  logic          dp_en;
  logic [2:0]    dp_pos;
  logic          busy, done, overflow;
  logic [5:0]    d1, d2, d3, d4, d5, d6, d7, d8;
  logic [5:0]    d_dut [8];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  dspl_bin2digits #(.VALUE_W(VW), .MAX_VALUE(MAXV)) dut (
    .clock(clock), .reset(reset), .start(start), .value_in(value_in),
    .blank_lz(blank_lz), .dp_en(dp_en), .dp_pos(dp_pos),
    .busy(busy), .done(done), .overflow(overflow),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8)
  );

  assign d_dut[0] = d1;
  assign d_dut[1] = d2;
  assign d_dut[2] = d3;
  assign d_dut[3] = d4;
  assign d_dut[4] = d5;
  assign d_dut[5] = d6;
  assign d_dut[6] = d7;
  assign d_dut[7] = d8;

  typedef struct {
    int unsigned     value;
    bit              blank;
    bit              dpen;
    int              dppos;
    logic [7:0][5:0] exp_d;   // [0] = d1
    bit              exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: digits from decimal division, blanking from magnitude.
  function automatic logic [5:0] model_word(input int unsigned v, input bit blank,
                                            input bit dpen, input int dppos, input int k);
    int unsigned p;
    int unsigned digit;
    bit          en;
    if (v > MAXV) return (k == 0) ? 6'b111101 : 6'b000001;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    digit = (v / p) % 10;
    en = !blank || (k == 0) || (v >= p) || (dpen && k <= dppos);
    if (!en) return 6'b000001;
    return {1'b1, digit[3:0], !(dpen && k == dppos)};
  endfunction

  task automatic add_vec(input int unsigned v, input bit b, input bit de, input int dp,
                         input logic [47:0] ex, input bit eo);
    vec_t t;
    t.value = v; t.blank = b; t.dpen = de; t.dppos = dp; t.exp_d = ex; t.exp_ovf = eo;
    vecs.push_back(t);
  endtask

  // Counts edges after the accepting edge until done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic convert(input int unsigned v, input bit blank, input bit dpen,
                         input int dppos, output int lat);
    @(negedge clock);
    value_in = VW'(v);
    blank_lz = blank;
    dp_en    = dpen;
    dp_pos   = 3'(dppos);
    start    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done(lat);
  endtask

  task automatic check_model(input string tag, input int unsigned v, input bit blank,
                             input bit dpen, input int dppos);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s_d%0d", tag, k + 1), 32'(d_dut[k]), 32'(model_word(v, blank, dpen, dppos, k)));
    check($sformatf("%s_ovf", tag), 32'(overflow), 32'(v > MAXV));
  endtask

  task automatic check_all_off(input string tag);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s_d%0d", tag, k + 1), 32'(d_dut[k]), 32'(6'b000001));
  endtask

  initial begin
    int          lat;
    int          ndone;
    int unsigned v;
    bit          b, de;
    int          dp;

    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          ndone;
    int unsigned v;
    bit          b, de;
    int          dp;

    reset = 1'b1; start = 1'b0; value_in = '0; blank_lz = 1'b0; dp_en = 1'b0; dp_pos = 3'd0;
    repeat (2) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check_all_off("rst");
    reset = 1'b0;

    // Table of directed vectors with hand-derived words, {d8 .. d1}.
    add_vec(12345678, 0, 0, 0, {6'b100011, 6'b100101, 6'b100111, 6'b101001,
                                6'b101011, 6'b101101, 6'b101111, 6'b110001}, 0);
    add_vec(42, 1, 0, 0, {{6{6'b000001}}, 6'b101001, 6'b100101}, 0);
    add_vec(5, 1, 1, 2, {{5{6'b000001}}, 6'b100000, 6'b100001, 6'b101011}, 0);
    add_vec(100000000, 0, 1, 3, {{7{6'b000001}}, 6'b111101}, 1);
    add_vec(0, 1, 0, 0, {{7{6'b000001}}, 6'b100001}, 0);
    add_vec(0, 0, 1, 7, {6'b100000, {7{6'b100001}}}, 0);
    add_vec(99999999, 1, 0, 0, {8{6'b110011}}, 0);
    add_vec(10000000, 1, 1, 0, {6'b100011, {6{6'b100001}}, 6'b100000}, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      convert(vecs[i].value, vecs[i].blank, vecs[i].dpen, vecs[i].dppos, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(VW + 1));
      for (int k = 0; k < 8; k++)
        check($sformatf("vec%0d_d%0d", i, k + 1), 32'(d_dut[k]), 32'(vecs[i].exp_d[k]));
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
    end

    // Random values against the decimal model.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0:       v = $urandom_range(0, 9);
        1:       v = $urandom_range(0, 99999);
        2:       v = $urandom_range(0, 99999999);
        3:       v = $urandom_range(99999990, 100000010);
        default: v = $urandom_range(0, (1 << VW) - 1);
      endcase
      b  = 1'($urandom_range(0, 1));
      de = 1'($urandom_range(0, 1));
      dp = int'($urandom_range(0, 7));
      convert(v, b, de, dp, lat);
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(VW + 1));
      check_model($sformatf("rnd%0d", i), v, b, de, dp);
    end

    // Start pulsed mid-conversion is neither taken nor queued.
    @(negedge clock);
    value_in = VW'(777); blank_lz = 1'b1; dp_en = 1'b0; dp_pos = 3'd0; start = 1'b1;
    @(posedge clock);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clock);
      if (c == 5) begin
        value_in = VW'(123);
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = c - 1;
        break;
      end
      @(posedge clock);
    end
    check("ignore_latency", 32'(lat), 32'(VW + 1));
    check_model("ignore", 777, 1, 0, 0);
    repeat (3) @(negedge clock);
    check("ignore_not_queued", 32'(busy), 32'd0);

    // Start held high: one result every VW+2 cycles, done a single cycle wide.
    @(negedge clock);
    value_in = VW'(31415926); blank_lz = 1'b0; dp_en = 1'b0; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    wait_done(lat);
    check("held_first_latency", 32'(lat), 32'(VW + 1));
    check_model("held", 31415926, 0, 0, 0);
    @(posedge clock);
    @(negedge clock);
    check("held_done_single", 32'(done), 32'd0);
    lat = 1;
    for (int c = 2; c <= 100; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (done) begin
        lat = c;
        break;
      end
      if (c == 100) lat = -1;
    end
    check("held_period", 32'(lat), 32'(VW + 2));
    start = 1'b0;

    // Reset ten cycles into a conversion that follows an overflow result.
    convert(123456789, 0, 0, 0, lat);
    check("pre_reset_ovf", 32'(overflow), 32'd1);
    @(negedge clock);
    value_in = VW'(55); start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    check_all_off("midrst");
    @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
